// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit map and EX/MEM payload width.
package riscv_pipe_pkg;

  localparam int CTRL_BRANCH   = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_W        = 5;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  // ctrl + branch target + alu result + store data + zero flag + rd
  localparam int EXMEM_PAYLOAD_W = CTRL_W + 3 * DATA_W_DEF + 1 + REG_W_DEF;

  function automatic int exmem_payload_w(input int data_w, input int reg_w);
    return CTRL_W + 3 * data_w + 1 + reg_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: head register drives the outputs,
// skid register absorbs one extra entry so in_ready can be registered.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         head_vld_q, head_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop, head_free;

  assign push      = in_valid & in_ready_q;
  assign pop       = head_vld_q & out_ready;
  assign head_free = ~head_vld_q | pop;

  // Next-state: skid always refills the head first so ordering stays FIFO.
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      // A pop this cycle has already been sampled by MEM; a push is dropped.
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (head_free) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = push;
        if (push) skid_d = in_data;
      end else if (push) begin
        head_d     = in_data;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (push) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
    in_ready_d = ~skid_vld_d;
  end

  // State registers; in_ready is held low throughout reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = head_vld_q;
  assign out_data  = head_q;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage: packs the EX outputs into one payload, passes it
// through a 2-entry skid buffer, gates ctrl on bubbles and counts stalls.
module ex_mem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = riscv_pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] branch_tgt_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] store_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] branch_tgt_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] store_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [CNT_W-1:0]  stall_cnt
);
  import riscv_pipe_pkg::*;

  localparam int PW = exmem_payload_w(DATA_W, REG_W);

  logic [PW-1:0]     pay_in, pay_out;
  logic [CTRL_W-1:0] ctrl_head;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign pay_in = {ctrl_in, branch_tgt_in, alu_res_in, zero_in, store_in, rd_in};

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {ctrl_head, branch_tgt_out, alu_res_out, zero_out, store_out, rd_out} = pay_out;

  // A bubble must never carry RegWrite/MemWrite, so ctrl is forced to zero.
  assign ctrl_out = out_valid ? ctrl_head : '0;

  // Saturating count of cycles where MEM holds the head entry back.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ex_mem_skid_stage;
  import riscv_pipe_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 5;
  localparam int NW = 4;
  localparam int SMAX = 15;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] bt;
    logic [DW-1:0] alu;
    logic          z;
    logic [DW-1:0] st;
    logic [RW-1:0] rd;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] ctrl_in = '0;
  logic [DW-1:0] branch_tgt_in = '0;
  logic [DW-1:0] alu_res_in = '0;
  logic          zero_in = 1'b0;
  logic [DW-1:0] store_in = '0;
  logic [RW-1:0] rd_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] ctrl_out;
  logic [DW-1:0] branch_tgt_out;
  logic [DW-1:0] alu_res_out;
  logic          zero_out;
  logic [DW-1:0] store_out;
  logic [RW-1:0] rd_out;
  logic [NW-1:0] stall_cnt;

  ex_mem_skid_stage #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .branch_tgt_in(branch_tgt_in), .alu_res_in(alu_res_in),
    .zero_in(zero_in), .store_in(store_in), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .branch_tgt_out(branch_tgt_out), .alu_res_out(alu_res_out),
    .zero_out(zero_out), .store_out(store_out), .rd_out(rd_out),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents of at most two entries, stall count, and
  // whether the stage has seen a clock edge since reset released.
  ent_t q[$];
  int   m_stall = 0;
  bit   m_started = 1'b0;
  bit   chk_en = 1'b0;

  always @(posedge clk) begin
    ent_t cur;
    bit   push, pop;
    cur = '{ctrl: ctrl_in, bt: branch_tgt_in, alu: alu_res_in, z: zero_in,
            st: store_in, rd: rd_in};
    if (!reset) begin
      q.delete();
      m_stall   = 0;
      m_started = 1'b0;
    end else begin
      if (q.size() > 0 && !out_ready && m_stall != SMAX) m_stall++;
      push = in_valid && m_started && q.size() < 2;
      pop  = q.size() > 0 && out_ready;
      if (flush) q.delete();
      else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(cur);
      end
      m_started = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_in_ready", in_ready, m_started && q.size() < 2);
      chk("m_ctrl_out", ctrl_out, q.size() > 0 ? q[0].ctrl : '0);
      chk("m_stall_cnt", stall_cnt, m_stall);
      if (q.size() > 0) begin
        chk("m_alu", alu_res_out, q[0].alu);
        chk("m_bt", branch_tgt_out, q[0].bt);
        chk("m_st", store_out, q[0].st);
        chk("m_z", zero_out, q[0].z);
        chk("m_rd", rd_out, q[0].rd);
      end
    end
  end

  task automatic offer(input logic v, input logic [DW-1:0] val, input logic [CW-1:0] c);
    in_valid      = v;
    alu_res_in    = val;
    branch_tgt_in = val + 32'h1000;
    store_in      = ~val;
    zero_in       = val[0];
    rd_in         = val[RW-1:0];
    ctrl_in       = c;
  endtask

  localparam logic [CW-1:0] C_RW = 5'b1 << CTRL_REGWRITE;
  localparam logic [CW-1:0] C_RWMW = (5'b1 << CTRL_REGWRITE) | (5'b1 << CTRL_MEMWRITE);

  initial begin
    // 1: reset with in_valid asserted
    offer(1'b1, 32'hdead, C_RW);
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_ctrl", ctrl_out, 0);
    chk("t1_stall", stall_cnt, 0);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_alu_zero", alu_res_out, 0);
    reset = 1'b1;
    offer(1'b0, 0, 0);
    @(negedge clk);
    chk("t1_in_ready_rel", in_ready, 1);

    // 2: stream 1..8 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin
        chk("t2_valid", out_valid, 1);
        chk("t2_alu", alu_res_out, i - 1);
      end
      if (i <= 8) offer(1'b1, i, C_RW);
      else        offer(1'b0, 0, 0);
      @(negedge clk);
    end
    chk("t2_empty", out_valid, 0);

    // 3: back-pressure with three entries offered
    out_ready = 1'b0;
    offer(1'b1, 100, C_RW);
    @(negedge clk);
    chk("t3_rdy1", in_ready, 1);
    offer(1'b1, 101, C_RW);
    @(negedge clk);
    chk("t3_rdy2", in_ready, 0);
    chk("t3_stall1", stall_cnt, 1);
    offer(1'b1, 102, C_RW);
    @(negedge clk);
    chk("t3_rdy3", in_ready, 0);
    chk("t3_stall2", stall_cnt, 2);
    chk("t3_head", alu_res_out, 100);
    offer(1'b0, 0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_drain_alu", alu_res_out, 101);
    chk("t3_drain_rdy", in_ready, 1);
    @(negedge clk);
    chk("t3_drained", out_valid, 0);
    chk("t3_stall_hold", stall_cnt, 2);

    // 4: flush with two entries held and a push offered
    out_ready = 1'b0;
    offer(1'b1, 200, C_RWMW);
    @(negedge clk);
    offer(1'b1, 201, C_RWMW);
    @(negedge clk);
    offer(1'b1, 202, C_RWMW);
    flush = 1'b1;
    @(negedge clk);
    chk("t4_valid", out_valid, 0);
    chk("t4_ctrl", ctrl_out, 0);
    chk("t4_rdy", in_ready, 1);
    flush = 1'b0;
    offer(1'b0, 0, 0);
    @(negedge clk);
    chk("t4_dropped", out_valid, 0);
    chk("t4_stall", stall_cnt, 4);

    // 5: stall counter saturation
    offer(1'b1, 300, C_RW);
    @(negedge clk);
    offer(1'b0, 0, 0);
    repeat (20) @(negedge clk);
    chk("t5_sat", stall_cnt, 15);
    repeat (3) @(negedge clk);
    chk("t5_sat_hold", stall_cnt, 15);
    chk("t5_head", alu_res_out, 300);

    // reset clears the counter and the held entry
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_stall", stall_cnt, 0);
    chk("t5_rst_valid", out_valid, 0);
    reset = 1'b1;
    @(negedge clk);

    // 6: random traffic against the model
    for (int n = 0; n < 10000; n++) begin
      offer($urandom_range(0, 9) < 6, $urandom, CW'($urandom));
      out_ready = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end
    offer(1'b0, 0, 0);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_final_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
